// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller and datapath:
// state encodings, opcode constants and datapath select constants.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0000,
    S_FETCH   = 4'b0001,
    S_ADDIEX  = 4'b0010,
    S_ADDIWR  = 4'b0011,
    S_BNEEX   = 4'b0100,
    S_DECODE  = 4'b0101,
    S_MEMADR  = 4'b0110,
    S_LBRD    = 4'b0111,
    S_LBWR    = 4'b1000,
    S_SBWR    = 4'b1001,
    S_RTYPEEX = 4'b1010,
    S_RTYPEWR = 4'b1011,
    S_BEQEX   = 4'b1100,
    S_JEX     = 4'b1101,
    S_ERR     = 4'b1111
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that stall on the memory ready handshake.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_LBRD) || (s == S_SBWR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter with timeout compare.
// Ports: clk, reset (async active-low), waiting (in a wait state with
// mem_ready=0), timeout_c (combinational: limit reached while still waiting).
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  output logic timeout_c
);

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q, cnt_d;

  // The FSM only holds its state while waiting (or in ERR), so clearing
  // whenever not waiting is the same as clearing on every state change.
  always_comb begin
    timeout_c = 1'b0;
    if (MEM_TIMEOUT != 0) begin
      timeout_c = waiting && (cnt_q == CW'(MEM_TIMEOUT));
    end
    cnt_d = '0;
    if (waiting && !timeout_c) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mc_controller_v2.sv
// Multicycle MIPS-subset control FSM (LB, SB, R-type, BEQ, J, ADDI, BNE)
// with memory ready handshake, wait timeout and illegal-opcode reporting.
// Ports: clk, reset (async active-low), op, zero, mem_ready in;
// datapath strobes, pcen, pcsource/alusrcb/aluop selects, illegal pulse,
// sticky err and state_o debug out. Outputs decode from the state register.
module mc_controller_v2 #(
  parameter int unsigned OPW          = 6,
  parameter int unsigned SUPPORT_ADDI = 1,
  parameter int unsigned SUPPORT_BNE  = 1,
  parameter int unsigned TRAP_ILLEGAL = 0,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           memread,
  output logic           memwrite,
  output logic           alusrca,
  output logic           memtoreg,
  output logic           iord,
  output logic           regwrite,
  output logic           regdst,
  output logic           irwrite,
  output logic           pcen,
  output logic [1:0]     pcsource,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic           illegal,
  output logic           err,
  output logic [3:0]     state_o
);

  import mc_ctrl_pkg::*;

  state_t state_q, state_d;
  logic   timeout_c;
  logic   waiting;
  logic   is_lb, is_sb, is_rtype, is_beq, is_j, is_addi, is_bne;
  logic   pcwrite, pcwritecond;

  assign is_lb    = (op == OPW'(OP_LB));
  assign is_sb    = (op == OPW'(OP_SB));
  assign is_rtype = (op == OPW'(OP_RTYPE));
  assign is_beq   = (op == OPW'(OP_BEQ));
  assign is_j     = (op == OPW'(OP_J));
  assign is_addi  = (SUPPORT_ADDI != 0) && (op == OPW'(OP_ADDI));
  assign is_bne   = (SUPPORT_BNE != 0) && (op == OPW'(OP_BNE));

  assign waiting = is_mem_wait_state(state_q) && !mem_ready;

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .waiting   (waiting),
    .timeout_c (timeout_c)
  );

  // Next-state logic; illegal pulses while DECODE sees an undecodable op.
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timeout_c) state_d = S_ERR;
      end
      S_DECODE: begin
        if (is_lb || is_sb) state_d = S_MEMADR;
        else if (is_rtype)  state_d = S_RTYPEEX;
        else if (is_beq)    state_d = S_BEQEX;
        else if (is_j)      state_d = S_JEX;
        else if (is_addi)   state_d = S_ADDIEX;
        else if (is_bne)    state_d = S_BNEEX;
        else begin
          illegal = 1'b1;
          state_d = (TRAP_ILLEGAL != 0) ? S_ERR : S_FETCH;
        end
      end
      S_MEMADR: begin
        if (is_lb)      state_d = S_LBRD;
        else if (is_sb) state_d = S_SBWR;
        else            state_d = S_FETCH;
      end
      S_LBRD: begin
        if (mem_ready)      state_d = S_LBWR;
        else if (timeout_c) state_d = S_ERR;
      end
      S_SBWR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timeout_c) state_d = S_ERR;
      end
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_ADDIEX:  state_d = S_ADDIWR;
      S_LBWR, S_RTYPEWR, S_ADDIWR,
      S_BEQEX, S_BNEEX, S_JEX: state_d = S_FETCH;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Strobe decode; FETCH commits IR/PC only in the cycle memory completes.
  always_comb begin
    memread     = 1'b0;
    memwrite    = 1'b0;
    alusrca     = 1'b0;
    memtoreg    = 1'b0;
    iord        = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = PCSRC_ALU;
    alusrcb     = ALUSRCB_REG;
    aluop       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = ALUSRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = ALUSRCB_BRANCH;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        aluop   = ALUOP_ADD;
      end
      S_LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_ADDIWR: regwrite = 1'b1;
      S_BEQEX, S_BNEEX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
      end
      S_JEX: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
      end
      default: ;
    endcase
    // BNE takes the branch on a nonzero compare, BEQ on zero.
    pcen = pcwrite | (pcwritecond & ((state_q == S_BNEEX) ? ~zero : zero));
  end

  assign err     = (state_q == S_ERR);
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_controller_v2.sv
// Directed bench for mc_controller_v2. Two instances share the stimulus:
// dut A (traps off, BNE on) and dut B (illegal trap on, BNE unsupported),
// both with a wait timeout of 4. Expected state/strobe vectors are queued
// per cycle and checked shortly after the falling edge.
module tb_mc_controller_v2;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic a_memread, a_memwrite, a_alusrca, a_memtoreg, a_iord, a_regwrite;
  logic a_regdst, a_irwrite, a_pcen, a_illegal, a_err;
  logic [1:0] a_pcsource, a_alusrcb, a_aluop;
  logic [3:0] a_state;
  logic b_memread, b_memwrite, b_alusrca, b_memtoreg, b_iord, b_regwrite;
  logic b_regdst, b_irwrite, b_pcen, b_illegal, b_err;
  logic [1:0] b_pcsource, b_alusrcb, b_aluop;
  logic [3:0] b_state;

  mc_controller_v2 #(.OPW(6), .SUPPORT_ADDI(1), .SUPPORT_BNE(1),
                     .TRAP_ILLEGAL(0), .MEM_TIMEOUT(4)) u_dut_a (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(a_memread), .memwrite(a_memwrite), .alusrca(a_alusrca),
    .memtoreg(a_memtoreg), .iord(a_iord), .regwrite(a_regwrite),
    .regdst(a_regdst), .irwrite(a_irwrite), .pcen(a_pcen),
    .pcsource(a_pcsource), .alusrcb(a_alusrcb), .aluop(a_aluop),
    .illegal(a_illegal), .err(a_err), .state_o(a_state)
  );

  mc_controller_v2 #(.OPW(6), .SUPPORT_ADDI(1), .SUPPORT_BNE(0),
                     .TRAP_ILLEGAL(1), .MEM_TIMEOUT(4)) u_dut_b (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .memread(b_memread), .memwrite(b_memwrite), .alusrca(b_alusrca),
    .memtoreg(b_memtoreg), .iord(b_iord), .regwrite(b_regwrite),
    .regdst(b_regdst), .irwrite(b_irwrite), .pcen(b_pcen),
    .pcsource(b_pcsource), .alusrcb(b_alusrcb), .aluop(b_aluop),
    .illegal(b_illegal), .err(b_err), .state_o(b_state)
  );

  logic [20:0] a_obs, b_obs;
  assign a_obs = {a_state, a_memread, a_memwrite, a_alusrca, a_memtoreg, a_iord,
                  a_regwrite, a_regdst, a_irwrite, a_pcen, a_pcsource, a_alusrcb,
                  a_aluop, a_illegal, a_err};
  assign b_obs = {b_state, b_memread, b_memwrite, b_alusrca, b_memtoreg, b_iord,
                  b_regwrite, b_regdst, b_irwrite, b_pcen, b_pcsource, b_alusrcb,
                  b_aluop, b_illegal, b_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          sel;
    logic [20:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_pass = 0;
  int  n_fail = 0;
  int  n_total = 0;

  localparam logic [5:0] LB = 6'b100000, SB = 6'b101000, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BNE = 6'b000101, BAD = 6'b111111;

  // Order: memread memwrite alusrca memtoreg iord regwrite regdst irwrite pcen
  //        pcsource alusrcb aluop illegal err
  function automatic logic [16:0] ov(input logic mr, mw, asa, m2r, io, rw, rd,
                                     irw, pce, input logic [1:0] pcs, asb, aop,
                                     input logic ill, er);
    return {mr, mw, asa, m2r, io, rw, rd, irw, pce, pcs, asb, aop, ill, er};
  endfunction

  logic [16:0] E_0, E_FW, E_FR, E_DEC, E_DILL, E_ADR, E_LBRD, E_LBWR, E_SBWR;
  logic [16:0] E_RTEX, E_RTWR, E_AWR, E_BRT, E_BRN, E_JEX, E_ERR;

  task automatic tick(input logic [5:0] o, input logic z, input logic mr,
                      input logic rst);
    @(negedge clk);
    op = o; zero = z; mem_ready = mr; reset = rst;
  endtask

  task automatic expect_st(input string tag, input bit sel, input logic [3:0] st,
                           input logic [16:0] v);
    sb_t e;
    e.tag = tag; e.sel = sel; e.exp = {st, v};
    sbq.push_back(e);
  endtask

  task automatic check_all();
    sb_t e;
    logic [20:0] obs;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      obs = e.sel ? b_obs : a_obs;
      n_total++;
      assert (obs === e.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed state=%b outs=%b expected state=%b outs=%b",
               e.tag, obs[20:17], obs[16:0], e.exp[20:17], e.exp[16:0]);
      end
    end
  endtask

  // One cycle on dut A only.
  task automatic run_a(input logic [5:0] o, input logic z, input logic mr,
                       input string tag, input logic [3:0] st, input logic [16:0] v);
    tick(o, z, mr, 1'b1);
    expect_st(tag, 1'b0, st, v);
    check_all();
  endtask

  task automatic reset_both(input string tag);
    tick(RT, 1'b0, 1'b1, 1'b0);
    expect_st({tag, "_a"}, 1'b0, 4'b0000, E_0);
    expect_st({tag, "_b"}, 1'b1, 4'b0000, E_0);
    check_all();
    tick(RT, 1'b0, 1'b1, 1'b1);
    expect_st({tag, "_rel_a"}, 1'b0, 4'b0000, E_0);
    expect_st({tag, "_rel_b"}, 1'b1, 4'b0000, E_0);
    check_all();
    tick(RT, 1'b0, 1'b1, 1'b1);
    expect_st({tag, "_fetch_a"}, 1'b0, 4'b0001, E_FR);
    expect_st({tag, "_fetch_b"}, 1'b1, 4'b0001, E_FR);
    check_all();
  endtask

  initial begin
    reset = 1'b0; op = RT; zero = 1'b0; mem_ready = 1'b1;
    E_0    = '0;
    E_FW   = ov(1,0,0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b00, 0,0);
    E_FR   = ov(1,0,0,0,0,0,0,1,1, 2'b00, 2'b01, 2'b00, 0,0);
    E_DEC  = ov(0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 0,0);
    E_DILL = ov(0,0,0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b00, 1,0);
    E_ADR  = ov(0,0,1,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 0,0);
    E_LBRD = ov(1,0,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_LBWR = ov(0,0,0,1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_SBWR = ov(0,1,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_RTEX = ov(0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0,0);
    E_RTWR = ov(0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_AWR  = ov(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 0,0);
    E_BRT  = ov(0,0,1,0,0,0,0,0,1, 2'b01, 2'b00, 2'b01, 0,0);
    E_BRN  = ov(0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b01, 0,0);
    E_JEX  = ov(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0);
    E_ERR  = ov(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,1);

    // Reset held low for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      tick(RT, 1'b0, 1'b1, 1'b0);
      expect_st("rst_low_a", 1'b0, 4'b0000, E_0);
      expect_st("rst_low_b", 1'b1, 4'b0000, E_0);
      check_all();
    end
    tick(RT, 1'b0, 1'b1, 1'b1);
    expect_st("rst_rel_a", 1'b0, 4'b0000, E_0);
    check_all();
    run_a(ADDI, 0, 1, "first_fetch", 4'b0001, E_FR);

    // ADDI
    run_a(ADDI, 0, 1, "addi_dec", 4'b0101, E_DEC);
    run_a(ADDI, 0, 1, "addi_ex",  4'b0010, E_ADR);
    run_a(ADDI, 0, 1, "addi_wr",  4'b0011, E_AWR);
    run_a(BNE,  0, 1, "fetch",    4'b0001, E_FR);
    // BNE not-zero (taken), BNE zero (not taken)
    run_a(BNE, 0, 1, "bne_dec",   4'b0101, E_DEC);
    run_a(BNE, 0, 1, "bne_nz",    4'b0100, E_BRT);
    run_a(BNE, 1, 1, "fetch",     4'b0001, E_FR);
    run_a(BNE, 1, 1, "bne_dec",   4'b0101, E_DEC);
    run_a(BNE, 1, 1, "bne_z",     4'b0100, E_BRN);
    run_a(BEQ, 1, 1, "fetch",     4'b0001, E_FR);
    // BEQ zero (taken), BEQ not-zero (not taken)
    run_a(BEQ, 1, 1, "beq_dec",   4'b0101, E_DEC);
    run_a(BEQ, 1, 1, "beq_z",     4'b1100, E_BRT);
    run_a(BEQ, 0, 1, "fetch",     4'b0001, E_FR);
    run_a(BEQ, 0, 1, "beq_dec",   4'b0101, E_DEC);
    run_a(BEQ, 0, 1, "beq_nz",    4'b1100, E_BRN);
    run_a(LB,  0, 1, "fetch",     4'b0001, E_FR);
    // LB with three wait cycles in LBRD
    run_a(LB, 0, 1, "lb_dec",     4'b0101, E_DEC);
    run_a(LB, 0, 1, "lb_adr",     4'b0110, E_ADR);
    for (int i = 0; i < 3; i++) run_a(LB, 0, 0, "lbrd_wait", 4'b0111, E_LBRD);
    run_a(LB, 0, 1, "lbrd_done",  4'b0111, E_LBRD);
    run_a(LB, 0, 1, "lbwr",       4'b1000, E_LBWR);
    run_a(SB, 0, 1, "fetch",      4'b0001, E_FR);
    // SB with one wait cycle
    run_a(SB, 0, 1, "sb_dec",     4'b0101, E_DEC);
    run_a(SB, 0, 1, "sb_adr",     4'b0110, E_ADR);
    run_a(SB, 0, 0, "sbwr_wait",  4'b1001, E_SBWR);
    run_a(SB, 0, 1, "sbwr_done",  4'b1001, E_SBWR);
    run_a(RT, 0, 1, "fetch",      4'b0001, E_FR);
    // R-type and J
    run_a(RT, 0, 1, "rt_dec",     4'b0101, E_DEC);
    run_a(RT, 0, 1, "rt_ex",      4'b1010, E_RTEX);
    run_a(RT, 0, 1, "rt_wr",      4'b1011, E_RTWR);
    run_a(JMP, 0, 1, "fetch",     4'b0001, E_FR);
    run_a(JMP, 0, 1, "j_dec",     4'b0101, E_DEC);
    run_a(JMP, 0, 1, "j_ex",      4'b1101, E_JEX);
    run_a(BAD, 0, 1, "fetch",     4'b0001, E_FR);
    // Illegal without trap: one-cycle pulse, back to FETCH
    run_a(BAD, 0, 1, "ill_dec",   4'b0101, E_DILL);
    // Completion on the limit cycle wins over the timeout
    for (int i = 0; i < 4; i++) run_a(JMP, 0, 0, "fetch_wait", 4'b0001, E_FW);
    run_a(JMP, 0, 1, "fetch_at_limit", 4'b0001, E_FR);
    run_a(JMP, 0, 1, "limit_dec",      4'b0101, E_DEC);
    run_a(JMP, 0, 1, "limit_j",        4'b1101, E_JEX);
    // Stuck memory: five wait cycles, then ERR, sticky
    for (int i = 0; i < 5; i++) run_a(JMP, 0, 0, "fetch_stuck", 4'b0001, E_FW);
    for (int i = 0; i < 3; i++) run_a(JMP, 0, 1, "err_sticky", 4'b1111, E_ERR);

    // Asynchronous reset out of ERR
    reset_both("rst_err");

    // Illegal opcode: A returns to FETCH, B traps
    tick(BAD, 0, 1, 1);
    expect_st("ill_dec_a", 1'b0, 4'b0101, E_DILL);
    expect_st("ill_dec_b", 1'b1, 4'b0101, E_DILL);
    check_all();
    tick(BAD, 0, 1, 1);
    expect_st("ill_next_a", 1'b0, 4'b0001, E_FR);
    expect_st("ill_trap_b", 1'b1, 4'b1111, E_ERR);
    check_all();
    tick(BAD, 0, 1, 1);
    expect_st("trap_sticky_b", 1'b1, 4'b1111, E_ERR);
    check_all();

    // BNE unsupported on B: illegal pulse then trap; A executes it
    reset_both("rst_bne");
    tick(BNE, 0, 1, 1);
    expect_st("bne_dec_a",   1'b0, 4'b0101, E_DEC);
    expect_st("bne_unsup_b", 1'b1, 4'b0101, E_DILL);
    check_all();
    tick(BNE, 0, 1, 1);
    expect_st("bne_ex_a",    1'b0, 4'b0100, E_BRT);
    expect_st("bne_trap_b",  1'b1, 4'b1111, E_ERR);
    check_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_controller_v2.md
Name: mc_controller_v2

Overview:
Parametrised multicycle MIPS-subset control FSM, the successor to the current five-instruction controller.
- Drives the same datapath control strobes as before.
- Adds ADDI and BNE execution.
- Adds a memory ready handshake with wait states, a bounded wait timeout with a sticky error, and illegal-opcode reporting.
- Sits between instruction register opcode/ALU zero flag and the multicycle datapath.

Parameters:
OPW, 6, opcode field width.
SUPPORT_ADDI, 1, 1 = ADDI (op 001000) decoded; 0 = treated as illegal.
SUPPORT_BNE, 1, 1 = BNE (op 000101) decoded; 0 = treated as illegal.
TRAP_ILLEGAL, 0, 1 = illegal opcode enters ERR; 0 = returns to FETCH.
MEM_TIMEOUT, 15, max consecutive wait cycles before ERR; 0 disables timeout.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
op  in  OPW  instruction opcode
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, irwrite  out  1  datapath strobes
pcen  out  1  PC write enable
pcsource, alusrcb, aluop  out  2  datapath selects
illegal  out  1  one-cycle pulse on an undecodable opcode
err  out  1  sticky error, cleared only by reset
state_o  out  4  current state, for debug

Behaviour:
- State register: asynchronous clear to IDLE when reset=0.
- All outputs are decoded from the state, plus mem_ready/zero qualifiers.
- In IDLE every output is 0, so every output reads 0 during and immediately after reset.
- State encodings:
  - IDLE=0000, FETCH=0001, DECODE=0101, MEMADR=0110, LBRD=0111, LBWR=1000, SBWR=1001
  - RTYPEEX=1010, RTYPEWR=1011, BEQEX=1100, JEX=1101, ADDIEX=0010, ADDIWR=0011, BNEEX=0100, ERR=1111
- Transitions:
  - IDLE->FETCH unconditionally.
  - FETCH->DECODE when mem_ready=1, otherwise stay in FETCH.
  - DECODE dispatch on op:
    - LB (100000) and SB (101000) -> MEMADR
    - RTYPE (000000) -> RTYPEEX
    - BEQ (000100) -> BEQEX
    - J (000010) -> JEX
    - ADDI -> ADDIEX
    - BNE -> BNEEX
    - anything else -> illegal path (see below)
  - MEMADR: LB->LBRD, SB->SBWR, else FETCH.
  - LBRD->LBWR when mem_ready=1, else hold.
  - SBWR->FETCH when mem_ready=1, else hold.
  - LBWR, RTYPEWR, ADDIWR, BEQEX, BNEEX, JEX -> FETCH.
  - RTYPEEX->RTYPEWR; ADDIEX->ADDIWR.
  - ERR holds until reset.
- Illegal path: in DECODE with an undecodable op, illegal=1 for that cycle; next state is ERR if TRAP_ILLEGAL=1, else FETCH.
- Strobes per state (unlisted outputs are 0):
  - FETCH: memread=1, alusrcb=01; irwrite=1 and pcwrite=1 only in the cycle mem_ready=1.
  - DECODE: alusrcb=11.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - LBRD: memread=1, iord=1 (held through wait).
  - LBWR: regwrite=1, memtoreg=1.
  - SBWR: memwrite=1, iord=1 (held through wait).
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWR: regdst=1, regwrite=1.
  - ADDIWR: regwrite=1, regdst=0, memtoreg=0.
  - BEQEX and BNEEX: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JEX: pcwrite=1, pcsource=10.
  - ERR: all strobes 0.
- pcen = pcwrite | (pcwritecond & (state==BNEEX ? ~zero : zero)). pcen is combinational from zero.
- Wait counter:
  - Width clog2(MEM_TIMEOUT+1), minimum 1.
  - Clears on every state change.
  - Increments each cycle spent in FETCH/LBRD/SBWR with mem_ready=0.
- Timeout: when MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT with mem_ready still 0, the next state is ERR and the counter stops.
- mem_ready=1 on the same cycle the counter reaches MEM_TIMEOUT: completion wins, no error.
- err=1 iff state==ERR. err is 0 in IDLE.
- Reset asserted mid-wait or mid-instruction: immediate return to IDLE, no partial strobe beyond the clearing edge.
- Latencies with zero wait states:
  - LB = 5 cycles; SB, RTYPE and ADDI = 4; BEQ, BNE and J = 3.
  - Each memory wait cycle adds 1.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state encodings;
  - the opcode constants LB, SB, RTYPE, BEQ, J, ADDI, BNE;
  - the ALUOP/ALUSRCB/PCSOURCE select constants.
- The datapath and the v1 controller reuse the package.
- One sub-module: mc_wait_timer (counter, clear-on-state-change, timeout compare, MEM_TIMEOUT=0 bypass).

Test Plan:
- Reset low for 3 cycles, then release with mem_ready tied 1 -> every output is 0 and state_o=0000 while low, state_o=0001 one cycle after release, irwrite=pcen=1 in FETCH.
- Run ADDI (op=001000) with mem_ready=1 -> state sequence 0001, 0101, 0010, 0011, 0001; ADDIWR has regwrite=1, regdst=0.
- BNE with zero=0, then BNE with zero=1 -> pcen=1 in BNEEX for the first, pcen=0 for the second; BEQ behaves inversely.
- LB with mem_ready=0 for 3 cycles in LBRD, then 1 -> memread=iord=1 held 4 cycles, then LBWR with regwrite=memtoreg=1.
- MEM_TIMEOUT=4, FETCH with mem_ready stuck 0 -> ERR entered after the 5th wait cycle, err=1 stays set until reset; a second run with mem_ready=1 on the counter==4 cycle -> no error.
- op=111111: TRAP_ILLEGAL=0 gives an illegal pulse for 1 cycle then FETCH; TRAP_ILLEGAL=1 gives ERR. Repeat with SUPPORT_BNE=0 and op=000101 -> illegal pulse.
